muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//   Iterative multiply/divide unit with HI/LO registers; sits directly downstream of the register file.
//   Consumes the two register read ports (rs -> a, rt -> b) for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
//   Supplies hi/lo to the writeback mux for MFHI/MFLO.
//   The control unit stalls the PC while busy=1.
//   Datapath: radix-2 shift-add multiply and restoring divide, one bit per cycle.
// PARAMETERS
//   WIDTH  32  operand width; hi and lo are each WIDTH bits; iteration count = WIDTH
// PORTS
//   clk    in   1      clock, all state updates on posedge
//   rst    in   1      reset: asynchronous, active-low (0 = reset)
//   start  in   1      request; sampled only when idle (busy=0)
//   op     in   3      muldiv_pkg op code: NOP, MULT, MULTU, DIV, DIVU, MTHI, MTLO
//   a      in   WIDTH  rs value (multiplicand / dividend / MTHI-MTLO source)
//   b      in   WIDTH  rt value (multiplier / divisor)
//   busy   out  1      1 while an iterative operation is in flight
//   done   out  1      one-cycle pulse: hi/lo now hold the new result
//   hi     out  WIDTH  HI register (product[63:32] / remainder)
//   lo     out  WIDTH  LO register (product[31:0] / quotient)
// BEHAVIOUR
//   Reset (rst=0, any time, including mid-operation):
//     state=IDLE; busy=0, done=0, hi=0, lo=0; counter and working registers cleared.
//     In-flight operation is discarded.
//   FSM states:
//     IDLE -> RUN on start with MULT/MULTU/DIV/DIVU.
//     RUN  -> FIX after WIDTH iterations (counter WIDTH-1 down to 0).
//     FIX  -> IDLE.
//   Start edge (IDLE):
//     latch |a| and |b| (signed ops) or a and b (unsigned ops); latch sign flags and op.
//     busy=1 from the next cycle.
//   RUN: one iteration per clock.
//     mul: add-if-lsb, shift right into 2*WIDTH accumulator.
//     div: shift remainder left, trial subtract, set quotient bit.
//   FIX edge:
//     apply sign correction; write hi/lo; done<=1 and busy<=0 on the same edge.
//   Latency:
//     done is high in the cycle WIDTH+2 clocks after the start edge (34 for WIDTH=32).
//     hi/lo hold their old values until then.
//   Signed results:
//     product negated when sign(a)!=sign(b).
//     quotient negated when sign(a)!=sign(b); remainder takes the sign of a.
//   Divide by zero (b=0, DIV or DIVU): lo=all ones, hi=a unmodified; no sign correction.
//   Signed overflow DIV -2^31 / -1: lo=0x80000000, hi=0 (falls out of the magnitude path).
//   MTHI / MTLO with start in IDLE:
//     hi<=a or lo<=a on that edge; single cycle.
//     busy stays 0; done is not pulsed; the state does not change.
//   start while busy=1: ignored (no restart, operands not re-latched).
//   start in the done cycle: accepted (state is IDLE).
//   op=NOP or an undefined code with start=1: no effect.
//   done deasserts after exactly one cycle unless a new operation completes.
// STRUCTURE
//   muldiv_pkg:
//     op code localparams (NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6)
//     FSM state encodings (IDLE, RUN, FIX)
//     WIDTH default
//   Sub-module muldiv_signfix (combinational):
//     abs of the inputs; conditional negate of a WIDTH or 2*WIDTH value.
//     Used at the start and FIX edges.
//   Everything else lives in muldiv_unit: FSM, counter, accumulator, divisor, hi/lo.
// TESTING
//   1. Reset: rst=0 mid-RUN (cycle 10 of MULT).
//      -> busy=0, done=0, hi=lo=0 immediately.
//      After release, MULTU 3*5 completes normally: lo=15, hi=0.
//   2. MULT a=-7 (0xFFFFFFF9), b=6.
//      -> done in cycle 34, hi=0xFFFFFFFF, lo=0xFFFFFFD6; busy high for cycles 1..33.
//   3. MULTU a=0xFFFFFFFF, b=0xFFFFFFFF.
//      -> hi=0xFFFFFFFE, lo=0x00000001.
//   4. DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
//      DIVU a=7, b=2 -> lo=3, hi=1.
//   5. Boundaries:
//      DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=100.
//      DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
//   6. Concurrency:
//      start=1 (MULTU 2*2) at cycle 5 of a running DIV -> ignored; DIV result unchanged.
//      MTLO a=0x1234 while idle -> lo=0x1234 next cycle, busy=0, done=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM encoding and default width for the multiply/divide unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // Only MULT and DIV treat their operands as two's complement.
  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Sign handling for the muldiv datapath: operand magnitudes and result negation.
// Latency: purely combinational.
// Backpressure: none.
//   a, b          operands; a_abs/b_abs are magnitudes when sgn=1, else pass-through
//   a_neg, b_neg  operand is negative (only meaningful when sgn=1)
//   x_in/x_out    2*WIDTH value, negated when x_neg (product, or zero-extended quotient)
//   y_in/y_out    WIDTH value, negated when y_neg (remainder)
module muldiv_signfix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sgn,
  output logic [WIDTH-1:0]   a_abs,
  output logic [WIDTH-1:0]   b_abs,
  output logic               a_neg,
  output logic               b_neg,
  input  logic [2*WIDTH-1:0] x_in,
  input  logic               x_neg,
  output logic [2*WIDTH-1:0] x_out,
  input  logic [WIDTH-1:0]   y_in,
  input  logic               y_neg,
  output logic [WIDTH-1:0]   y_out
);

  assign a_neg = sgn & a[WIDTH-1];
  assign b_neg = sgn & b[WIDTH-1];

  // The most negative value maps onto itself, which is the correct unsigned magnitude.
  assign a_abs = a_neg ? (~a + 1'b1) : a;
  assign b_abs = b_neg ? (~b + 1'b1) : b;

  assign x_out = x_neg ? (~x_in + 1'b1) : x_in;
  assign y_out = y_neg ? (~y_in + 1'b1) : y_in;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide with HI/LO result registers.
// Latency: done pulses WIDTH+2 clocks after the start edge; MTHI/MTLO take one edge.
// Backpressure: busy=1 while iterating; start is ignored until busy drops.
//   clk, rst  clock; asynchronous active-low reset
//   start,op  request and op code, sampled only in IDLE
//   a, b      rs / rt operands
//   busy      operation in flight
//   done      one-cycle pulse when hi/lo take a new result
//   hi, lo    HI (product upper / remainder), LO (product lower / quotient)
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

  state_t             state;
  logic [CW-1:0]      cnt;
  // mul: {partial product, remaining multiplier}; div: {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb;      // multiplicand or divisor magnitude
  logic               is_div;
  logic               neg_lo;   // negate product / quotient at FIX
  logic               neg_hi;   // negate remainder at FIX

  logic [WIDTH-1:0]   a_abs, b_abs;
  logic               a_neg, b_neg;
  logic               b_zero;
  logic [2*WIDTH-1:0] fix_x_in, fix_x_out;
  logic [WIDTH-1:0]   fix_y_out;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;

  assign b_zero   = (b == '0);
  assign fix_x_in = is_div ? {{WIDTH{1'b0}}, acc[WIDTH-1:0]} : acc;

  muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
    .a     (a),
    .b     (b),
    .sgn   (is_signed_op(op)),
    .a_abs (a_abs),
    .b_abs (b_abs),
    .a_neg (a_neg),
    .b_neg (b_neg),
    .x_in  (fix_x_in),
    .x_neg (neg_lo),
    .x_out (fix_x_out),
    .y_in  (acc[2*WIDTH-1:WIDTH]),
    .y_neg (neg_hi),
    .y_out (fix_y_out)
  );

  // One iteration of each algorithm; RUN picks the one for the latched op.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb};
    // Remainder stays below the divisor, so bit WIDTH of the difference is its sign.
    if (!div_diff[WIDTH]) begin
      div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      acc    <= '0;
      opb    <= '0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                acc    <= {{WIDTH{1'b0}}, b_abs};
                opb    <= a_abs;
                is_div <= 1'b0;
                neg_lo <= a_neg ^ b_neg;
                neg_hi <= 1'b0;
                cnt    <= CNT_TOP;
                busy   <= 1'b1;
                state  <= ST_RUN;
              end
              OP_DIV, OP_DIVU: begin
                // Divide by zero: feed the raw dividend through a zero divisor so the
                // quotient comes out all ones and the remainder equals a, unsigned.
                acc    <= {{WIDTH{1'b0}}, (b_zero ? a : a_abs)};
                opb    <= b_abs;
                is_div <= 1'b1;
                neg_lo <= ~b_zero & (a_neg ^ b_neg);
                neg_hi <= ~b_zero & a_neg;
                cnt    <= CNT_TOP;
                busy   <= 1'b1;
                state  <= ST_RUN;
              end
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          acc <= is_div ? div_next : mul_next;
          if (cnt == '0) begin
            state <= ST_FIX;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_FIX: begin
          if (is_div) begin
            lo <= fix_x_out[WIDTH-1:0];
            hi <= fix_y_out;
          end else begin
            lo <= fix_x_out[WIDTH-1:0];
            hi <= fix_x_out[2*WIDTH-1:WIDTH];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized ops vs a reference model.
// Latency: expects done exactly 34 clocks after the start edge.
// Backpressure: checks that start is ignored while busy.
module tb_muldiv_unit;

  localparam logic [2:0] T_NOP   = 3'd0;
  localparam logic [2:0] T_MULT  = 3'd1;
  localparam logic [2:0] T_MULTU = 3'd2;
  localparam logic [2:0] T_DIV   = 3'd3;
  localparam logic [2:0] T_DIVU  = 3'd4;
  localparam logic [2:0] T_MTHI  = 3'd5;
  localparam logic [2:0] T_MTLO  = 3'd6;
  localparam int         LAT     = 34;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic; returns {hi, lo}.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    longint unsigned ux, uy;
    logic [63:0] q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      T_MULT:  return sx * sy;
      T_MULTU: return ux * uy;
      T_DIV: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      T_DIVU: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        q = ux / uy;
        r = ux % uy;
        return {r[31:0], q[31:0]};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Drives one start cycle; returns at the negedge of the first cycle after the start edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input bit now);
    if (!now) @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    op    = T_NOP;
    a     = $urandom;
    b     = $urandom;
  endtask

  // Bounded wait; cyc counts cycles since the start edge (1 = first cycle after it).
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 80) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    int c;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      failures++;
      $display("FAIL reset_state busy=%b done=%b hi=%h lo=%h want all zero", busy, done, hi, lo);
    end
    rst = 1'b1;
    @(negedge clk);
    issue(T_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b0);
    issue(T_MTLO, 32'hCAFE_F00D, 32'd0, 1'b0);
    issue(T_MULT, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      failures++;
      $display("FAIL reset_midrun busy=%b done=%b hi=%h lo=%h want all zero", busy, done, hi, lo);
    end
    @(negedge clk);
    rst = 1'b1;
    issue(T_MULTU, 32'd3, 32'd5, 1'b0);
    wait_done(c);
    checks++;
    if (c != LAT || hi !== 32'd0 || lo !== 32'd15) begin
      failures++;
      $display("FAIL reset_then_multu cyc=%0d hi=%h lo=%h want cyc=%0d hi=0 lo=f", c, hi, lo, LAT);
    end
  endtask

  task automatic test_mult_signed();
    issue(T_MTHI, 32'h0000_AAAA, 32'd0, 1'b0);
    issue(T_MTLO, 32'h0000_5555, 32'd0, 1'b0);
    issue(T_MULT, 32'hFFFF_FFF9, 32'd6, 1'b0);
    for (int c = 1; c <= LAT + 1; c++) begin
      checks++;
      if (busy !== (c <= LAT - 1) || done !== (c == LAT)) begin
        failures++;
        $display("FAIL mult_timing cycle=%0d busy=%b done=%b want busy=%b done=%b",
                 c, busy, done, (c <= LAT - 1), (c == LAT));
      end
      if (c < LAT) begin
        checks++;
        if (hi !== 32'h0000_AAAA || lo !== 32'h0000_5555) begin
          failures++;
          $display("FAIL mult_hold cycle=%0d hi=%h lo=%h want hi=0000aaaa lo=00005555", c, hi, lo);
        end
      end else begin
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFD6) begin
          failures++;
          $display("FAIL mult_neg7x6 cycle=%0d hi=%h lo=%h want hi=ffffffff lo=ffffffd6", c, hi, lo);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_directed();
    logic [2:0]  ops [6] = '{T_MULTU, T_DIV, T_DIVU, T_DIVU, T_DIV, T_MULT};
    logic [31:0] xs  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd7, 32'd100, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] ys  [6] = '{32'hFFFF_FFFF, 32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [63:0] exp [6] = '{64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0001_0000_0003,
                            64'h0000_0064_FFFF_FFFF, 64'h0000_0000_8000_0000, 64'h4000_0000_0000_0000};
    int c;
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], xs[i], ys[i], 1'b0);
      wait_done(c);
      checks++;
      if (c != LAT || {hi, lo} !== exp[i]) begin
        failures++;
        $display("FAIL directed_%0d op=%0d a=%h b=%h cyc=%0d hi=%h lo=%h want cyc=%0d %h",
                 i, ops[i], xs[i], ys[i], c, hi, lo, LAT, exp[i]);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        failures++;
        $display("FAIL done_pulse_%0d done=%b want 0", i, done);
      end
    end
  endtask

  task automatic test_concurrency();
    int c;
    issue(T_DIV, 32'hFFFF_FF9C, 32'd7, 1'b0);   // -100 / 7
    repeat (4) @(negedge clk);
    start = 1'b1;
    op    = T_MULTU;
    a     = 32'd2;
    b     = 32'd2;
    @(negedge clk);
    start = 1'b0;
    op    = T_NOP;
    wait_done(c);
    c = c + 5;
    checks++;
    if (c != LAT || hi !== 32'hFFFF_FFFE || lo !== 32'hFFFF_FFF2) begin
      failures++;
      $display("FAIL start_while_busy cyc=%0d hi=%h lo=%h want cyc=%0d hi=fffffffe lo=fffffff2",
               c, hi, lo, LAT);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL no_restart busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_move_and_nop();
    issue(T_MTHI, 32'h0000_7777, 32'd0, 1'b0);
    issue(T_MTLO, 32'h0000_1234, 32'd0, 1'b0);
    checks++;
    if (lo !== 32'h0000_1234 || hi !== 32'h0000_7777 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL mtlo lo=%h hi=%h busy=%b done=%b want lo=00001234 hi=00007777 busy=0 done=0",
               lo, hi, busy, done);
    end
    issue(T_NOP, 32'h1111_1111, 32'd3, 1'b0);
    issue(3'd7, 32'h2222_2222, 32'd3, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (lo !== 32'h0000_1234 || hi !== 32'h0000_7777 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL nop_undef lo=%h hi=%h busy=%b done=%b want lo=00001234 hi=00007777 busy=0 done=0",
               lo, hi, busy, done);
    end
  endtask

  task automatic test_back_to_back();
    int c;
    issue(T_DIVU, 32'd7, 32'd2, 1'b0);
    wait_done(c);
    checks++;
    if (c != LAT || hi !== 32'd1 || lo !== 32'd3) begin
      failures++;
      $display("FAIL divu_7_2 cyc=%0d hi=%h lo=%h want cyc=%0d hi=1 lo=3", c, hi, lo, LAT);
    end
    issue(T_MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b1);   // start in the done cycle
    wait_done(c);
    checks++;
    if (c != LAT || hi !== 32'd0 || lo !== 32'd15) begin
      failures++;
      $display("FAIL start_in_done_cycle cyc=%0d hi=%h lo=%h want cyc=%0d hi=0 lo=f", c, hi, lo, LAT);
    end
  endtask

  task automatic test_random();
    logic [31:0] pool [6] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd13};
    logic [2:0]  o;
    logic [31:0] x, y;
    logic [63:0] exp;
    int c;
    for (int i = 0; i < 48; i++) begin
      o = 3'($urandom_range(1, 4));
      x = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
      y = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 2) == 0) y = y >> $urandom_range(8, 31);
      exp = model(o, x, y);
      issue(o, x, y, (i % 4) == 3);
      wait_done(c);
      checks++;
      if (c != LAT || {hi, lo} !== exp) begin
        failures++;
        $display("FAIL random_%0d op=%0d a=%h b=%h cyc=%0d hi=%h lo=%h want cyc=%0d %h",
                 i, o, x, y, c, hi, lo, LAT, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult_signed();
    test_directed();
    test_concurrency();
    test_move_and_nop();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
